instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall_f_i, input, 1, hazard-unit fetch stall.
REQ-005 SHALL have port redirect_i, input, 1, taken branch/jump from execute.
REQ-006 SHALL have port redirect_target_i, input, 32, redirect destination.
REQ-007 SHALL have port imem_addr_o, output, 32, fetch address to instruction memory.
REQ-008 SHALL have port imem_rd_i, input, 32, instruction word from memory.
REQ-009 SHALL have port instr_hit_f_i, input, 1, instruction word is valid this cycle.
REQ-010 SHALL have port ic_repl_permit_i, input, 1, in-flight miss may be abandoned.
REQ-011 SHALL have ports instr_d_o, pc_d_o and pc_plus4_d_o, output, 32 each, decode-stage instruction, PC and PC+4.
REQ-012 SHALL have port valid_d_o, output, 1, decode slot holds a live instruction.
REQ-013 SHALL have port ready_d_i, input, 1, decode consumes the slot this cycle.
REQ-014 SHALL have port misalign_o, output, 1, one-cycle pulse when a redirect target has nonzero bits [1:0].

Function
REQ-015 SHALL drive imem_addr_o combinationally from the registered fetch PC (pc_f).
REQ-016 SHALL implement states FETCH, MISS and REDIR_WAIT.
REQ-017 SHALL treat the slot as free when valid_d_o is 0 or ready_d_i is 1.
REQ-018 SHALL accept a fetch when all hold: state FETCH (or MISS with hit), instr_hit_f_i=1, slot free, stall_f_i=0, redirect_i=0.
REQ-019 On accept, SHALL set instr_d_o=imem_rd_i, pc_d_o=pc_f, pc_plus4_d_o=pc_f+4, valid_d_o=1 and pc_f=pc_f+4, all next edge.
REQ-020 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 SHALL clear valid_d_o when valid_d_o=1, ready_d_i=1 and no accept occurs.
REQ-022 SHALL hold valid_d_o and all D outputs while valid_d_o=1 and ready_d_i=0.
REQ-023 In FETCH with instr_hit_f_i=0 and no redirect, SHALL enter MISS and hold pc_f.
REQ-024 In MISS with instr_hit_f_i=1, SHALL return to FETCH, accepting the word that cycle if REQ-018 allows.
REQ-025 redirect_i SHALL take priority over stall_f_i, accept and miss handling.
REQ-026 On redirect, SHALL force valid_d_o=0 next edge (flush).
REQ-027 Redirect in FETCH, or in MISS with ic_repl_permit_i=1, SHALL set pc_f={redirect_target_i[31:2],2'b00} and state FETCH.
REQ-028 Redirect in MISS with ic_repl_permit_i=0 SHALL latch the aligned target into pend_pc, hold pc_f and enter REDIR_WAIT.
REQ-029 In REDIR_WAIT, a new redirect SHALL overwrite pend_pc and keep valid_d_o=0.
REQ-030 In REDIR_WAIT, SHALL discard the word and perform no accept when instr_hit_f_i=1 or ic_repl_permit_i=1.
REQ-031 In the case of REQ-030, SHALL set pc_f=pend_pc and state FETCH.
REQ-032 In REDIR_WAIT, valid_d_o SHALL remain 0.
REQ-033 stall_f_i=1 without redirect SHALL freeze pc_f and state, and SHALL NOT accept.
REQ-034 stall_f_i=1 SHALL still allow REQ-021 draining.
REQ-035 misalign_o SHALL pulse for exactly the cycle after a redirect whose target[1:0]!=0.

Reset
REQ-036 On reset_i=1 at a clock edge: pc_f=RESET_PC, state FETCH, pend_pc=0, valid_d_o=0, instr_d_o=32'h0000_0013 (NOP), pc_d_o=0, pc_plus4_d_o=0, misalign_o=0.
REQ-037 reset_i SHALL override redirect, miss and stall, including mid-REDIR_WAIT.
REQ-038 Fetch SHALL begin the first cycle after reset_i deasserts.

Structure
REQ-039 Shared package SHALL hold the fetch_state_t enum (FETCH, MISS, REDIR_WAIT) and the NOP_INSTR constant 32'h0000_0013.
REQ-040 Module SHALL be self-contained with no sub-module; PC register and D-stage register are inline.

Verification
REQ-041 Verification SHALL cover: reset release, hit=1, ready=1 -> imem_addr_o 0,4,8 on consecutive cycles; pc_d_o and valid_d_o follow one cycle later.
REQ-042 Verification SHALL cover: hit=0 for 3 cycles at PC 0x10 -> imem_addr_o held 0x10, valid_d_o=0; on hit=1, instr_d_o captures data with pc_d_o=0x10.
REQ-043 Verification SHALL cover: ready_d_i=0 for 2 cycles with valid_d_o=1 -> D outputs and pc_f frozen; ready_d_i=1 resumes with no lost or duplicated PC.
REQ-044 Verification SHALL cover: redirect to 0x200 during MISS with permit=0, then a second redirect to 0x300, then permit=1 -> next imem_addr_o 0x300, no capture.
REQ-045 Verification SHALL cover: redirect to 0x102 -> imem_addr_o 0x100, misalign_o high for one cycle, valid_d_o=0.
REQ-046 Verification SHALL cover: pc_f=0xFFFF_FFFC accepted -> pc_plus4_d_o=0 and next imem_addr_o=0; reset asserted in REDIR_WAIT -> imem_addr_o=RESET_PC next cycle.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module : instr_fetch_unit_pkg
// Brief  : Shared fetch-state encoding and constants for the fetch unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      MISS       = 2'd1,
      REDIR_WAIT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] PC_INCREMENT = 32'd4;

endpackage : instr_fetch_unit_pkg

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetch PC, miss/redirect sequencing and the fetch->decode register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_f_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rd_i,
   input  logic        instr_hit_f_i,
   input  logic        ic_repl_permit_i,
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc_plus4_d_o,
   output logic        valid_d_o,
   input  logic        ready_d_i,
   output logic        misalign_o
);

   fetch_state_t state_q,     state_d;
   logic [31:0]  pc_f_q,      pc_f_d;
   logic [31:0]  pend_pc_q,   pend_pc_d;
   logic         dec_valid_q, dec_valid_d;
   logic [31:0]  dec_instr_q, dec_instr_d;
   logic [31:0]  dec_pc_q,    dec_pc_d;
   logic [31:0]  dec_pc4_q,   dec_pc4_d;
   logic         misalign_q,  misalign_d;

   logic         slot_free;
   logic         accept;
   logic [31:0]  tgt_aligned;
   logic [31:0]  pc_f_plus4;

   assign slot_free   = !dec_valid_q || ready_d_i;
   assign tgt_aligned = {redirect_target_i[31:2], 2'b00};
   assign pc_f_plus4  = pc_f_q + PC_INCREMENT;

   always_comb begin
      state_d     = state_q;
      pc_f_d      = pc_f_q;
      pend_pc_d   = pend_pc_q;
      dec_valid_d = dec_valid_q;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      dec_pc4_d   = dec_pc4_q;
      misalign_d  = redirect_i && (redirect_target_i[1:0] != 2'b00);
      accept      = 1'b0;

      if (redirect_i) begin
         dec_valid_d = 1'b0;
         case (state_q)
            REDIR_WAIT: pend_pc_d = tgt_aligned;
            MISS: begin
               // An unabandonable miss parks the target until the refill ends.
               if (ic_repl_permit_i) begin
                  pc_f_d  = tgt_aligned;
                  state_d = FETCH;
               end else begin
                  pend_pc_d = tgt_aligned;
                  state_d   = REDIR_WAIT;
               end
            end
            default: begin
               pc_f_d  = tgt_aligned;
               state_d = FETCH;
            end
         endcase
      end else if (stall_f_i) begin
         if (dec_valid_q && ready_d_i) begin
            dec_valid_d = 1'b0;
         end
      end else begin
         case (state_q)
            FETCH, MISS: begin
               if (instr_hit_f_i) begin
                  state_d = FETCH;
                  accept  = slot_free;
               end else begin
                  state_d = MISS;
               end
            end
            REDIR_WAIT: begin
               if (instr_hit_f_i || ic_repl_permit_i) begin
                  pc_f_d  = pend_pc_q;
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase

         if (accept) begin
            dec_valid_d = 1'b1;
            dec_instr_d = imem_rd_i;
            dec_pc_d    = pc_f_q;
            dec_pc4_d   = pc_f_plus4;
            pc_f_d      = pc_f_plus4;
         end else if (dec_valid_q && ready_d_i) begin
            dec_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= FETCH;
         pc_f_q      <= RESET_PC;
         pend_pc_q   <= 32'h0000_0000;
         dec_valid_q <= 1'b0;
         dec_instr_q <= NOP_INSTR;
         dec_pc_q    <= 32'h0000_0000;
         dec_pc4_q   <= 32'h0000_0000;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_f_q      <= pc_f_d;
         pend_pc_q   <= pend_pc_d;
         dec_valid_q <= dec_valid_d;
         dec_instr_q <= dec_instr_d;
         dec_pc_q    <= dec_pc_d;
         dec_pc4_q   <= dec_pc4_d;
         misalign_q  <= misalign_d;
      end
   end

   assign imem_addr_o  = pc_f_q;
   assign instr_d_o    = dec_instr_q;
   assign pc_d_o       = dec_pc_q;
   assign pc_plus4_d_o = dec_pc4_q;
   assign valid_d_o    = dec_valid_q;
   assign misalign_o   = misalign_q;

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed and randomized checks of instr_fetch_unit against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        reset_i, stall_f_i, redirect_i, instr_hit_f_i, ic_repl_permit_i, ready_d_i;
   logic [31:0] redirect_target_i, imem_rd_i;
   logic [31:0] imem_addr_o, instr_d_o, pc_d_o, pc_plus4_d_o;
   logic        valid_d_o, misalign_o;

   instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .stall_f_i        (stall_f_i),
      .redirect_i       (redirect_i),
      .redirect_target_i(redirect_target_i),
      .imem_addr_o      (imem_addr_o),
      .imem_rd_i        (imem_rd_i),
      .instr_hit_f_i    (instr_hit_f_i),
      .ic_repl_permit_i (ic_repl_permit_i),
      .instr_d_o        (instr_d_o),
      .pc_d_o           (pc_d_o),
      .pc_plus4_d_o     (pc_plus4_d_o),
      .valid_d_o        (valid_d_o),
      .ready_d_i        (ready_d_i),
      .misalign_o       (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: mode 0 = fetching, 1 = waiting on a miss, 2 = redirect parked.
   int          m_mode;
   logic [31:0] m_pc, m_pend, m_instr, m_pc_d, m_pc4;
   logic        m_valid, m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic        drain;
      logic [31:0] tgt;
      drain = m_valid && ready_d_i;
      tgt   = redirect_target_i & ~32'd3;
      if (reset_i) begin
         m_mode = 0; m_pc = RESET_PC; m_pend = 0; m_valid = 0;
         m_instr = NOP; m_pc_d = 0; m_pc4 = 0; m_mis = 0;
         return;
      end
      m_mis = redirect_i && ((redirect_target_i % 4) != 0);
      if (redirect_i) begin
         m_valid = 0;
         if (m_mode == 2) m_pend = tgt;
         else if (m_mode == 1 && !ic_repl_permit_i) begin m_pend = tgt; m_mode = 2; end
         else begin m_pc = tgt; m_mode = 0; end
      end else if (stall_f_i) begin
         if (drain) m_valid = 0;
      end else if (m_mode == 2) begin
         if (instr_hit_f_i || ic_repl_permit_i) begin m_pc = m_pend; m_mode = 0; end
      end else if (!instr_hit_f_i) begin
         m_mode = 1;
         if (drain) m_valid = 0;
      end else begin
         m_mode = 0;
         if (!m_valid || ready_d_i) begin
            m_instr = imem_rd_i; m_pc_d = m_pc; m_pc4 = m_pc + 4;
            m_pc = m_pc + 4; m_valid = 1;
         end
      end
   endtask

   task automatic step(input logic rst, input logic redir, input logic [31:0] tgt,
                       input logic stall, input logic hit, input logic permit, input logic ready);
      reset_i = rst; redirect_i = redir; redirect_target_i = tgt; stall_f_i = stall;
      instr_hit_f_i = hit; ic_repl_permit_i = permit; ready_d_i = ready;
      imem_rd_i = {m_pc[15:0], m_pc[31:16]} ^ $urandom;
      @(posedge clk_i);
      model_update();
      #1;
      chk("imem_addr", imem_addr_o, m_pc);
      chk("valid_d", {31'd0, valid_d_o}, {31'd0, m_valid});
      chk("instr_d", instr_d_o, m_instr);
      chk("pc_d", pc_d_o, m_pc_d);
      chk("pc_plus4_d", pc_plus4_d_o, m_pc4);
      chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
   endtask

   initial begin
      logic [31:0] cap;
      m_mode = 0; m_pc = RESET_PC; m_pend = 0; m_valid = 0;
      m_instr = NOP; m_pc_d = 0; m_pc4 = 0; m_mis = 0;

      // Reset state
      step(1, 1, 32'h0000_0123, 1, 0, 0, 1);
      step(1, 0, 0, 0, 1, 0, 1);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_instr", instr_d_o, NOP);

      // Streaming fetch: 0,4,8 with decode trailing by one cycle
      step(0, 0, 0, 0, 1, 0, 1);
      chk("seq_addr4", imem_addr_o, 32'h4);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      chk("seq_addr12", imem_addr_o, 32'hC);
      chk("seq_pcd8", pc_d_o, 32'h8);
      step(0, 0, 0, 0, 1, 0, 1);

      // Three-cycle miss at 0x10
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         chk("miss_hold", imem_addr_o, 32'h10);
         chk("miss_valid", {31'd0, valid_d_o}, 32'd0);
      end
      step(0, 0, 0, 0, 1, 0, 1);
      cap = imem_rd_i;
      chk("miss_pcd", pc_d_o, 32'h10);
      chk("miss_instr", instr_d_o, cap);

      // Decode back-pressure
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("bp_pcd", pc_d_o, 32'h10);
      chk("bp_addr", imem_addr_o, 32'h14);
      step(0, 0, 0, 0, 1, 0, 1);
      chk("bp_resume", pc_d_o, 32'h14);

      // Redirects parked behind an unabandonable miss
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 32'h200, 0, 0, 0, 1);
      chk("rw_hold", imem_addr_o, 32'h18);
      step(0, 1, 32'h300, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("rw_target", imem_addr_o, 32'h300);
      chk("rw_nocap", {31'd0, valid_d_o}, 32'd0);

      // Misaligned redirect
      step(0, 1, 32'h102, 0, 1, 0, 1);
      chk("mis_addr", imem_addr_o, 32'h100);
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("mis_end", {31'd0, misalign_o}, 32'd0);

      // PC wrap, then reset from REDIR_WAIT
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      chk("wrap_pc4", pc_plus4_d_o, 32'h0);
      chk("wrap_addr", imem_addr_o, 32'h0);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 32'h40, 0, 0, 0, 1);
      chk("rw_pre_rst", imem_addr_o, 32'h4);
      step(1, 1, 32'h80, 1, 1, 1, 1);
      chk("rw_rst_addr", imem_addr_o, RESET_PC);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 7) == 0),
              $urandom,
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_instr_fetch_unit

`default_nettype wire
